// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared op codes, register addresses and arbiter state type
package dp_pkg;

    localparam logic [2:0] NoOp  = 3'd0;
    localparam logic [2:0] Copy  = 3'd1;
    localparam logic [2:0] Load1 = 3'd2;
    localparam logic [2:0] Load2 = 3'd3;
    localparam logic [2:0] Add   = 3'd4;
    localparam logic [2:0] Sub   = 3'd5;
    localparam logic [2:0] Mul   = 3'd6;

    localparam logic [3:0] Disp    = 4'd0;
    localparam logic [3:0] Data0   = 4'd1;
    localparam logic [3:0] Data1   = 4'd2;
    localparam logic [3:0] Data2   = 4'd3;
    localparam logic [3:0] Data3   = 4'd4;
    localparam logic [3:0] DataNew = 4'd5;
    localparam logic [3:0] Coef0   = 4'd6;
    localparam logic [3:0] Coef1   = 4'd7;
    localparam logic [3:0] Coef2   = 4'd8;
    localparam logic [3:0] Coef3   = 4'd9;
    localparam logic [3:0] Temp    = 4'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        HANDOFF = 2'd3
    } arb_state_t;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter that wraps to zero after the rollover value
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] r_count;

    // clear wins over enable; an enabled count at the rollover value wraps to zero
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - two-requester datapath arbiter with hold timeout and round robin
module datapath_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [3:0] src1_0,
    input  logic [3:0] src2_0,
    input  logic [3:0] dest0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [3:0] src1_1,
    input  logic [3:0] src2_1,
    input  logic [3:0] dest1,
    input  logic       overflow,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ovf0,
    output logic       ovf1,
    output logic       preempt0,
    output logic       preempt1
);

    import dp_pkg::*;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last;
    logic       w_next_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_pre0;
    logic       r_pre1;
    logic       w_pre0;
    logic       w_pre1;
    logic       w_hold_clear;
    logic       w_hold_en;
    logic       w_at_limit;
    logic [3:0] w_hold_cnt;

    // Ownership is only ever entered from IDLE, so clearing there resets the count on every entry.
    assign w_hold_clear = (r_state == IDLE);
    assign w_hold_en    = ((r_state == OWN0) && req1) || ((r_state == OWN1) && req0);
    assign w_at_limit   = (w_hold_cnt == HOLD_LIMIT);

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_hold_counter (
        .clk          (clk),
        .n_rst        (n_reset),
        .clear        (w_hold_clear),
        .count_enable (w_hold_en),
        .rollover_val (HOLD_LIMIT),
        .count_out    (w_hold_cnt)
    );

    // next-state: round-robin arbitration in IDLE, release or timeout while owning
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_pre0       = 1'b0;
        w_pre1       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_next_state = r_last ? OWN0 : OWN1;
                end else if (req0) begin
                    w_next_state = OWN0;
                end else if (req1) begin
                    w_next_state = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    w_next_state = HANDOFF;
                    w_next_last  = 1'b0;
                end else if (req1 && w_at_limit) begin
                    w_next_state = HANDOFF;
                    w_next_last  = 1'b0;
                    w_pre0       = 1'b1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    w_next_state = HANDOFF;
                    w_next_last  = 1'b1;
                end else if (req0 && w_at_limit) begin
                    w_next_state = HANDOFF;
                    w_next_last  = 1'b1;
                    w_pre1       = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // state, grant, preempt and last-served registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_pre0  <= 1'b0;
            r_pre1  <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_gnt0  <= (w_next_state == OWN0);
            r_gnt1  <= (w_next_state == OWN1);
            r_pre0  <= w_pre0;
            r_pre1  <= w_pre1;
            r_last  <= w_next_last;
        end
    end

    // command and overflow routing follow the current owner; no owner means NoOp
    always_comb begin
        op   = NoOp;
        src1 = 4'd0;
        src2 = 4'd0;
        dest = 4'd0;
        ovf0 = 1'b0;
        ovf1 = 1'b0;
        case (r_state)
            OWN0: begin
                op   = op0;
                src1 = src1_0;
                src2 = src2_0;
                dest = dest0;
                ovf0 = overflow;
            end
            OWN1: begin
                op   = op1;
                src1 = src1_1;
                src2 = src2_1;
                dest = dest1;
                ovf1 = overflow;
            end
            default: begin
            end
        endcase
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign preempt0 = r_pre0;
    assign preempt1 = r_pre1;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - vector table, corner sequences and randomized model check for datapath_arbiter
module tb_datapath_arbiter;

    import dp_pkg::*;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       n_reset;
    logic       req0, req1, overflow;
    logic [2:0] op0, op1, op;
    logic [3:0] src1_0, src2_0, dest0, src1_1, src2_1, dest1;
    logic [3:0] src1, src2, dest;
    logic       gnt0, gnt1, ovf0, ovf1, preempt0, preempt1;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: who owns the datapath, whether a gap cycle is pending,
    // how many contested cycles the owner has used, and who was served last
    int m_owner;
    bit m_gap;
    int m_overlap;
    int m_last;
    bit m_pre0, m_pre1;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        ov;
        logic [20:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    datapath_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .req0     (req0),
        .op0      (op0),
        .src1_0   (src1_0),
        .src2_0   (src2_0),
        .dest0    (dest0),
        .req1     (req1),
        .op1      (op1),
        .src1_1   (src1_1),
        .src2_1   (src2_1),
        .dest1    (dest1),
        .overflow (overflow),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .ovf0     (ovf0),
        .ovf1     (ovf1),
        .preempt0 (preempt0),
        .preempt1 (preempt1)
    );

    function automatic logic [20:0] pack(input logic g0, input logic g1, input logic v0, input logic v1,
                                         input logic p0, input logic p1, input logic [2:0] o,
                                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        return {g0, g1, v0, v1, p0, p1, o, a, b, d};
    endfunction

    function automatic logic [20:0] e_own0(input logic v);
        return pack(1'b1, 1'b0, v, 1'b0, 1'b0, 1'b0, Mul, Data2, Coef2, Temp);
    endfunction

    function automatic logic [20:0] e_own1(input logic v);
        return pack(1'b0, 1'b1, 1'b0, v, 1'b0, 1'b0, Add, Data0, Data1, DataNew);
    endfunction

    function automatic logic [20:0] e_none(input logic p0, input logic p1);
        return pack(1'b0, 1'b0, 1'b0, 1'b0, p0, p1, NoOp, 4'd0, 4'd0, 4'd0);
    endfunction

    function automatic vec_t mk(input logic r0, input logic r1, input logic ov,
                                input logic [20:0] exp, input string name);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic logic [20:0] model_out();
        if (m_owner == 0)
            return pack(1'b1, 1'b0, overflow, 1'b0, m_pre0, m_pre1, op0, src1_0, src2_0, dest0);
        if (m_owner == 1)
            return pack(1'b0, 1'b1, 1'b0, overflow, m_pre0, m_pre1, op1, src1_1, src2_1, dest1);
        return e_none(m_pre0, m_pre1);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_gap = 1'b0; m_overlap = 0; m_last = 1; m_pre0 = 1'b0; m_pre1 = 1'b0;
    endtask

    task automatic model_release(input bit timed_out);
        if (timed_out && m_owner == 0) m_pre0 = 1'b1;
        if (timed_out && m_owner == 1) m_pre1 = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
    endtask

    task automatic model_step(input logic r0, input logic r1);
        logic mine, other;
        m_pre0 = 1'b0;
        m_pre1 = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            m_overlap = 0;
            if (r0 && r1)  m_owner = (m_last == 0) ? 1 : 0;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
        end else begin
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (!mine) begin
                model_release(1'b0);
            end else if (other) begin
                m_overlap++;
                if (m_overlap >= MAX_HOLD) model_release(1'b1);
            end
        end
    endtask

    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] got;
        got = pack(gnt0, gnt1, ovf0, ovf1, preempt0, preempt1, op, src1, src2, dest);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (gnt0 gnt1 ovf0 ovf1 pre0 pre1 op src1 src2 dest)",
                     name, got, exp);
        end
    endtask

    // one clock: model follows the inputs seen at the edge, outputs sampled at the falling edge
    task automatic tick();
        if (!n_reset) model_reset();
        else          model_step(req0, req1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fixed_cmds();
        op0 = Mul; src1_0 = Data2; src2_0 = Coef2; dest0 = Temp;
        op1 = Add; src1_1 = Data0; src2_1 = Data1; dest1 = DataNew;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        set_fixed_cmds();
        req0 = 1'b1; req1 = 1'b1; overflow = 1'b1;
        n_reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_state", e_none(1'b0, 1'b0));
        n_reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; overflow = 1'b0;

        tbl[0]  = mk(1, 0, 0, e_own0(1'b0),        "first_grant_passthrough");
        tbl[1]  = mk(1, 1, 1, e_own0(1'b1),        "own0_ovf_routed");
        tbl[2]  = mk(0, 1, 0, e_none(1'b0, 1'b0),  "release0_handoff");
        tbl[3]  = mk(0, 1, 0, e_none(1'b0, 1'b0),  "handoff_to_idle");
        tbl[4]  = mk(0, 1, 1, e_own1(1'b1),        "gnt1_two_after_release");
        tbl[5]  = mk(1, 1, 1, e_own1(1'b1),        "own1_holds");
        tbl[6]  = mk(1, 0, 0, e_none(1'b0, 1'b0),  "release1_handoff");
        tbl[7]  = mk(1, 0, 1, e_none(1'b0, 1'b0),  "idle_ovf_blocked");
        tbl[8]  = mk(1, 1, 0, e_own0(1'b0),        "rr_picks0");
        tbl[9]  = mk(0, 0, 0, e_none(1'b0, 1'b0),  "release0_again");
        tbl[10] = mk(0, 0, 0, e_none(1'b0, 1'b0),  "idle_again");
        tbl[11] = mk(1, 1, 0, e_own1(1'b0),        "rr_picks1");
        tbl[12] = mk(1, 0, 0, e_none(1'b0, 1'b0),  "release1_again");
        tbl[13] = mk(0, 1, 0, e_none(1'b0, 1'b0),  "req_in_handoff_ignored");
        tbl[14] = mk(0, 0, 0, e_none(1'b0, 1'b0),  "dropped_req_not_latched");
        tbl[15] = mk(0, 0, 0, e_none(1'b0, 1'b0),  "stays_idle");

        for (int i = 0; i < 16; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; overflow = tbl[i].ov;
            tick();
            check(tbl[i].name, tbl[i].exp);
        end

        // owner 0 keeps the datapath through 16 contested cycles, then is preempted
        req0 = 1'b0; req1 = 1'b0; overflow = 1'b0;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("hold_own0_c%0d", c), e_own0(1'b0));
        end
        tick(); check("timeout_handoff_pre0", e_none(1'b1, 1'b0));
        tick(); check("timeout_idle",         e_none(1'b0, 1'b0));
        tick(); check("timeout_gnt1",         e_own1(1'b0));

        // owner 0 releases in the very cycle the timeout fires: no preempt pulse
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 16; c++) tick();
        check("race_own0_c16", e_own0(1'b0));
        req0 = 1'b0;
        tick(); check("race_handoff_no_pre", e_none(1'b0, 1'b0));
        tick(); check("race_idle",           e_none(1'b0, 1'b0));
        tick(); check("race_gnt1",           e_own1(1'b0));

        // asynchronous reset while requester 1 owns the datapath
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        req1 = 1'b1;
        tick(); check("pre_reset_own1", e_own1(1'b0));
        req0 = 1'b1;
        tick(); check("pre_reset_own1_held", e_own1(1'b0));
        #2 n_reset = 1'b0;
        model_reset();
        #1 check("async_reset_immediate", e_none(1'b0, 1'b0));
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", e_none(1'b0, 1'b0));
        n_reset = 1'b1;
        tick(); check("after_reset_gnt0", e_own0(1'b0));

        // randomized traffic against the reference model
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            overflow = 1'($urandom_range(0, 1));
            op0    = 3'($urandom_range(0, 7));
            src1_0 = 4'($urandom_range(0, 15));
            src2_0 = 4'($urandom_range(0, 15));
            dest0  = 4'($urandom_range(0, 15));
            op1    = 3'($urandom_range(0, 7));
            src1_1 = 4'($urandom_range(0, 15));
            src2_1 = 4'($urandom_range(0, 15));
            dest1  = 4'($urandom_range(0, 15));
            n_reset = ($urandom_range(0, 299) != 0);
            tick();
            check($sformatf("rand_%0d", i), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
